rcv_ctrl: RTL and testbench

- Receive controller that sequences the byte receiver path: synchronises the serial input, detects start bits, samples 8 data bits at mid-bit, checks the stop bit, and buffers completed bytes in a small FIFO.
- Presents bytes to the downstream consumer through a valid/ready handshake.
- Sits between the serial pin and the byte-wide receive consumer, and drives the receive-status signals.

---
 rtl/rcv_pkg.sv | 15 +
 rtl/rcv_if.sv | 12 +
 rtl/rcv_fifo.sv | 52 +++++
 rtl/rcv_ctrl.sv | 144 ++++++++++++++
 tb/tb_rcv_ctrl.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/rcv_pkg.sv
// rtl/rcv_pkg.sv - shared types and constants for the byte receive controller
package rcv_pkg;

  localparam int BYTE_W         = 8;
  localparam int OVERSAMPLE_DEF = 16;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rcv_state_t;

endpackage

// File: rtl/rcv_if.sv
// rtl/rcv_if.sv - received-byte valid/ready stream between receiver and consumer
interface rcv_if;
  import rcv_pkg::*;

  logic [BYTE_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_ready;

  modport master (output rx_data, output rx_valid, input rx_ready);
  modport slave  (input rx_data, input rx_valid, output rx_ready);

endinterface

// File: rtl/rcv_fifo.sv
// rtl/rcv_fifo.sv - small synchronous FIFO holding completed receive bytes
module rcv_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is only accepted when a pop frees the slot on the same edge.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/rcv_ctrl.sv
// rtl/rcv_ctrl.sv - serial byte receiver: synchroniser, framing FSM and byte buffer
module rcv_ctrl
  import rcv_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int FIFO_DEPTH = 4
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   enable,
  input  logic   baud_tick,
  input  logic   rx_serial_in,
  rcv_if.master  rx,
  output logic   frame_err,
  output logic   overrun,
  output logic   busy
);

  localparam int            TW      = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] HALF_M1 = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FULL_M1 = TW'(OVERSAMPLE - 1);

  logic              sync1;
  logic              rx_s;
  rcv_state_t        state;
  logic [TW-1:0]     tick_cnt;
  logic [2:0]        bit_cnt;
  logic [BYTE_W-1:0] shreg;
  logic              push;
  logic              full;
  logic              empty;
  logic              pop;

  assign pop         = rx.rx_valid && rx.rx_ready;
  assign rx.rx_valid = !empty;

  rcv_fifo #(.WIDTH(BYTE_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (shreg),
    .pop       (pop),
    .full      (full),
    .empty     (empty),
    .head      (rx.rx_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) overrun <= 1'b0;
    else        overrun <= push && full && !pop;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1     <= 1'b1;
      rx_s      <= 1'b1;
      state     <= IDLE;
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      push      <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      sync1     <= rx_serial_in;
      rx_s      <= sync1;
      push      <= 1'b0;
      frame_err <= 1'b0;
      if (!enable) begin
        state    <= IDLE;
        busy     <= 1'b0;
        tick_cnt <= '0;
        bit_cnt  <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (!rx_s) begin
              state    <= START;
              busy     <= 1'b1;
              tick_cnt <= '0;
            end
          end
          START: begin
            if (baud_tick) begin
              if (tick_cnt == HALF_M1) begin
                tick_cnt <= '0;
                bit_cnt  <= '0;
                if (!rx_s) begin
                  state <= DATA;
                end else begin
                  state <= IDLE;
                  busy  <= 1'b0;
                end
              end else begin
                tick_cnt <= tick_cnt + TW'(1);
              end
            end
          end
          DATA: begin
            if (baud_tick) begin
              if (tick_cnt == FULL_M1) begin
                tick_cnt <= '0;
                shreg    <= {rx_s, shreg[BYTE_W-1:1]};
                bit_cnt  <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) state <= STOP;
              end else begin
                tick_cnt <= tick_cnt + TW'(1);
              end
            end
          end
          STOP: begin
            if (baud_tick) begin
              if (tick_cnt == FULL_M1) begin
                tick_cnt <= '0;
                if (rx_s) begin
                  push  <= 1'b1;
                  state <= IDLE;
                  busy  <= 1'b0;
                end else begin
                  frame_err <= 1'b1;
                  state     <= BREAK;
                end
              end else begin
                tick_cnt <= tick_cnt + TW'(1);
              end
            end
          end
          // Held-low line must return high before a new start can be recognised.
          BREAK: begin
            if (rx_s) begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rcv_ctrl.sv
// tb/tb_rcv_ctrl.sv - scoreboard bench for rcv_ctrl with randomised frames
module tb_rcv_ctrl;

  logic clk          = 1'b0;
  logic rst_n        = 1'b0;
  logic enable       = 1'b0;
  logic baud_tick    = 1'b0;
  logic rx_serial_in = 1'b1;
  logic frame_err;
  logic overrun;
  logic busy;

  rcv_if rxif ();

  rcv_ctrl #(.OVERSAMPLE(16), .FIFO_DEPTH(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .baud_tick    (baud_tick),
    .rx_serial_in (rx_serial_in),
    .rx           (rxif),
    .frame_err    (frame_err),
    .overrun      (overrun),
    .busy         (busy)
  );

  localparam int BIT_CLKS = 64;

  int         checks   = 0;
  int         failures = 0;
  int         cyc      = 0;
  int         fe_seen  = 0;
  int         ov_seen  = 0;
  int         exp_fe   = 0;
  int         exp_ov   = 0;
  bit         rand_ready = 1'b0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // baud_tick is high on every posedge whose index is a multiple of 4
  initial forever begin
    @(negedge clk);
    baud_tick = (cyc % 4 == 0);
  end

  initial forever begin
    @(negedge clk);
    if (rand_ready) rxif.rx_ready = 1'($urandom_range(0, 1));
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every handshake and tallies flag pulses.
  initial forever begin
    @(negedge clk);
    #1;
    if (rst_n) begin
      if (frame_err) fe_seen++;
      if (overrun) ov_seen++;
      if (frame_err && overrun) begin
        checks++;
        failures++;
        $display("FAIL flags_exclusive actual=both_high required=not_both");
      end
      if (rxif.rx_valid && rxif.rx_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_byte actual=%0h required=none", rxif.rx_data);
        end else begin
          check("rx_data", {24'h0, rxif.rx_data}, {24'h0, exp_q.pop_front()});
        end
      end
    end
  end

  // outcome: 0 nothing buffered, 1 byte expected downstream, 2 byte dropped by overrun
  task automatic send_frame(input logic [7:0] b, input logic stop_v, input int outcome,
                            input bit pulse_rdy, input int nbits);
    int         p;
    logic [9:0] frame;
    frame = {stop_v, b, 1'b0};
    do @(negedge clk); while (cyc % 4 != 1);
    p = cyc - 1;
    if (outcome == 1) exp_q.push_back(b);
    if (outcome == 2) exp_ov++;
    if (!stop_v && nbits == 10) exp_fe++;
    for (int k = 0; k < nbits * BIT_CLKS; k++) begin
      if (k > 0) @(negedge clk);
      rx_serial_in = frame[k / BIT_CLKS];
      // stop bit is sampled 608 clks after alignment; the push lands one edge later
      if (pulse_rdy) rxif.rx_ready = (cyc == p + 609);
    end
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    rand_ready    = 1'b0;
    rxif.rx_ready = 1'b1;
    while ((exp_q.size() != 0 || rxif.rx_valid) && n < 400) begin
      @(negedge clk);
      n++;
    end
    check({name, "_drained"}, exp_q.size(), 0);
    check({name, "_valid_low"}, {31'h0, rxif.rx_valid}, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

  initial begin
    logic [7:0] rb;
    bit         ok;
    rxif.rx_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valid", {31'h0, rxif.rx_valid}, 0);
    check("rst_data", {24'h0, rxif.rx_data}, 0);
    check("rst_busy", {31'h0, busy}, 0);
    check("rst_frame_err", {31'h0, frame_err}, 0);
    check("rst_overrun", {31'h0, overrun}, 0);
    rst_n         = 1'b1;
    enable        = 1'b1;
    rxif.rx_ready = 1'b1;
    repeat (8) @(negedge clk);

    // single byte
    send_frame(8'hA5, 1'b1, 1, 1'b0, 10);
    repeat (20) @(negedge clk);
    drain("single");
    check("single_busy", {31'h0, busy}, 0);
    check("single_no_fe", fe_seen, 0);

    // start glitch
    do @(negedge clk); while (cyc % 4 != 1);
    rx_serial_in = 1'b0;
    repeat (8) @(negedge clk);
    check("glitch_busy_start", {31'h0, busy}, 1);
    repeat (4) @(negedge clk);
    rx_serial_in = 1'b1;
    repeat (60) @(negedge clk);
    check("glitch_busy_idle", {31'h0, busy}, 0);
    check("glitch_no_push", {31'h0, rxif.rx_valid}, 0);
    check("glitch_no_fe", fe_seen, 0);

    // framing error, line held low, then a good frame
    send_frame(8'h3C, 1'b0, 0, 1'b0, 10);
    repeat (20) @(negedge clk);
    check("break_busy", {31'h0, busy}, 1);
    check("break_fifo_empty", {31'h0, rxif.rx_valid}, 0);
    repeat (20) @(negedge clk);
    rx_serial_in = 1'b1;
    repeat (10) @(negedge clk);
    check("break_exit_busy", {31'h0, busy}, 0);
    check("break_fe_count", fe_seen, exp_fe);
    send_frame(8'h11, 1'b1, 1, 1'b0, 10);
    repeat (10) @(negedge clk);
    drain("after_break");

    // overrun with consumer stalled
    rxif.rx_ready = 1'b0;
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, (i == 5) ? 2 : 1, 1'b0, 10);
    repeat (20) @(negedge clk);
    check("overrun_count", ov_seen, exp_ov);
    check("overrun_full_valid", {31'h0, rxif.rx_valid}, 1);
    drain("overrun");

    // push and pop on the same edge while full
    rxif.rx_ready = 1'b0;
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 1, (i == 5), 10);
    rxif.rx_ready = 1'b0;
    repeat (20) @(negedge clk);
    check("simul_no_overrun", ov_seen, exp_ov);
    drain("simul");

    // enable dropped while waiting for data bit 4
    send_frame(8'h5A, 1'b1, 0, 1'b0, 5);
    enable = 1'b0;
    repeat (2) @(negedge clk);
    check("disable_busy", {31'h0, busy}, 0);
    rx_serial_in = 1'b1;
    repeat (10) @(negedge clk);
    enable = 1'b1;
    repeat (10) @(negedge clk);
    send_frame(8'h7E, 1'b1, 1, 1'b0, 10);
    repeat (10) @(negedge clk);
    drain("reenable");

    // asynchronous reset mid-frame with a byte buffered
    rxif.rx_ready = 1'b0;
    send_frame(8'h33, 1'b1, 1, 1'b0, 10);
    send_frame(8'hC3, 1'b1, 0, 1'b0, 4);
    #3;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("async_rst_valid", {31'h0, rxif.rx_valid}, 0);
    check("async_rst_data", {24'h0, rxif.rx_data}, 0);
    check("async_rst_busy", {31'h0, busy}, 0);
    rx_serial_in = 1'b1;
    repeat (2) @(negedge clk);
    rst_n         = 1'b1;
    rxif.rx_ready = 1'b1;
    repeat (5) @(negedge clk);
    send_frame(8'h96, 1'b1, 1, 1'b0, 10);
    repeat (10) @(negedge clk);
    drain("after_reset");

    // random bytes, random stop validity, random consumer stalls
    rand_ready = 1'b1;
    for (int n = 0; n < 8; n++) begin
      rb = 8'($urandom);
      ok = ($urandom_range(0, 4) != 0);
      send_frame(rb, ok, ok ? 1 : 0, 1'b0, 10);
      if (!ok) begin
        repeat (4) @(negedge clk);
        rx_serial_in = 1'b1;
      end
      repeat ($urandom_range(6, 40)) @(negedge clk);
    end
    drain("random");
    check("final_fe_count", fe_seen, exp_fe);
    check("final_ov_count", ov_seen, exp_ov);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
